// File: rtl/hc595_shift_out_if.sv
// Controller-side pin bundle of the 74HC595-style serial-to-parallel expander.
// The controller drives DS/SHCP/STCP/OE and observes the cascade output Q7S.
interface hc595_shift_out_if;
  logic p14;  // DS
  logic p11;  // SHCP
  logic p12;  // STCP
  logic p13;  // OE, active-low
  logic p9;   // Q7S cascade out

  modport master (output p14, p11, p12, p13, input p9);
  modport slave  (input p14, p11, p12, p13, output p9);
endinterface

// File: rtl/hc595_shift_out.sv
// 74HC595 model: pin clocks are oversampled on clk and edge-detected; shift register
// feeds a storage register whose tri-state outputs are gated combinationally by OE.
module hc595_shift_out #(
  parameter logic CLEAR_STORAGE = 1'b1
) (
  input  logic             clk,
  input  logic             p10,
  hc595_shift_out_if.slave pins,
  output wire              p15,
  output wire              p1,
  output wire              p2,
  output wire              p3,
  output wire              p4,
  output wire              p5,
  output wire              p6,
  output wire              p7
);

  logic [7:0] sh_r;
  logic [7:0] st_r;
  logic       prev_p11_r;
  logic       prev_p12_r;
  logic       shcp_rise_s;
  logic       stcp_rise_s;

  // Rising-edge detection against the pin levels seen on the previous clk
  always_comb begin
    shcp_rise_s = pins.p11 & ~prev_p11_r;
    stcp_rise_s = pins.p12 & ~prev_p12_r;
  end

  // Edge history and shift register; history resets high so a pin held high is no edge
  always_ff @(posedge clk or negedge p10) begin
    if (!p10) begin
      sh_r       <= 8'h00;
      prev_p11_r <= 1'b1;
      prev_p12_r <= 1'b1;
    end else begin
      prev_p11_r <= pins.p11;
      prev_p12_r <= pins.p12;
      if (shcp_rise_s) begin
        sh_r <= {sh_r[6:0], pins.p14};
      end
    end
  end

  generate
    if (CLEAR_STORAGE) begin : g_st_clear
      // Storage register, cleared together with the shift register by MR
      always_ff @(posedge clk or negedge p10) begin
        if (!p10) begin
          st_r <= 8'h00;
        end else if (stcp_rise_s) begin
          st_r <= sh_r;
        end
      end
    end else begin : g_st_hold
      // Storage register that keeps its contents through MR, as on silicon
      always_ff @(posedge clk) begin
        if (p10 && stcp_rise_s) begin
          st_r <= sh_r;
        end
      end
    end
  endgenerate

  // A simultaneous SHCP/STCP edge latches the pre-shift value, since st_r samples old sh_r
  assign pins.p9 = sh_r[7];
  assign p15 = pins.p13 ? 1'bz : st_r[0];
  assign p1  = pins.p13 ? 1'bz : st_r[1];
  assign p2  = pins.p13 ? 1'bz : st_r[2];
  assign p3  = pins.p13 ? 1'bz : st_r[3];
  assign p4  = pins.p13 ? 1'bz : st_r[4];
  assign p5  = pins.p13 ? 1'bz : st_r[5];
  assign p6  = pins.p13 ? 1'bz : st_r[6];
  assign p7  = pins.p13 ? 1'bz : st_r[7];

endmodule
